alu_arbiter: RTL

- Shares the single-cycle 32-bit ALU between two requesters, e.g. port 0 = execute stage and port 1 = branch/address unit.
- Arbitration is round-robin with valid/ready handshakes.
- Drives alu_ip1/alu_ip2/alu_op_ctrl/alu_control/beq_inst, captures alu_out and beq_and_in1 into a registered response, and holds the response until the consumer accepts it.
- Rejects opcodes the ALU does not implement.

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for a shared single-cycle ALU; holds each response until accepted.
// Optional macro ALU_ARB_BYPASS_EN: start the next grant from RESP when the response is taken.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int MAX_OP = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req0_beq,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  input  logic              req1_beq,
  output logic [DATA_W-1:0] alu_ip1,
  output logic [DATA_W-1:0] alu_ip2,
  output logic [OP_W-1:0]   alu_op_ctrl,
  output logic              alu_control,
  output logic              beq_inst,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              beq_and_in1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_taken,
  output logic              rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] ip1_q, ip1_d, ip2_q, ip2_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              beq_q, beq_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_taken_q, rsp_taken_d;
  logic              rsp_err_q, rsp_err_d;

  logic arb_en, grant0, grant1, hs, op_legal;

  always_comb begin
    arb_en = (state_q == IDLE);
`ifdef ALU_ARB_BYPASS_EN
    arb_en = arb_en || ((state_q == RESP) && rsp_ready);
`endif
    arb_en = arb_en && !rst;
  end

  // On a tie the requester that was not granted last wins.
  assign grant0     = req0_valid && (!req1_valid || last_grant_q);
  assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
  assign req0_ready = arb_en && grant0;
  assign req1_ready = arb_en && grant1;
  assign hs         = req0_ready || req1_ready;

  assign op_legal    = (op_q <= OP_W'(MAX_OP));
  assign alu_control = (state_q == EXEC) && op_legal;
  assign beq_inst    = alu_control && beq_q;
  assign rsp_valid   = (state_q == RESP);

  assign alu_ip1     = ip1_q;
  assign alu_ip2     = ip2_q;
  assign alu_op_ctrl = op_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_taken   = rsp_taken_q;
  assign rsp_err     = rsp_err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ip1_d        = ip1_q;
    ip2_d        = ip2_q;
    op_d         = op_q;
    beq_d        = beq_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_taken_d  = rsp_taken_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: state_d = IDLE;
      EXEC: begin
        rsp_data_d  = op_legal ? alu_out : '0;
        rsp_taken_d = op_legal ? beq_and_in1 : 1'b0;
        rsp_err_d   = !op_legal;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A handshake (from IDLE, or from RESP in the bypass build) launches the next op.
    if (hs) begin
      ip1_d        = grant1 ? req1_a : req0_a;
      ip2_d        = grant1 ? req1_b : req0_b;
      op_d         = grant1 ? req1_op : req0_op;
      beq_d        = grant1 ? req1_beq : req0_beq;
      last_grant_d = grant1;
      rsp_id_d     = grant1;
      state_d      = EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      ip1_q        <= '0;
      ip2_q        <= '0;
      op_q         <= '0;
      beq_q        <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_taken_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ip1_q        <= ip1_d;
      ip2_q        <= ip2_d;
      op_q         <= op_d;
      beq_q        <= beq_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_taken_q  <= rsp_taken_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule
